// File: rtl/key_note_tracker_pkg.sv
// Shared constants and FSM state encoding for the PS/2 keyboard note tracker.
package key_note_tracker_pkg;

  localparam logic [5:0] SILENT_CODE = 6'd48;
  localparam logic [7:0] BRK_PREFIX  = 8'hF0;
  localparam logic [7:0] EXT_PREFIX  = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } kbd_state_t;

endpackage

// File: rtl/key_note_tracker_if.sv
// Scan-byte input strobe and note/gate outputs of the keyboard note tracker.
interface key_note_tracker_if;

  logic [7:0] scan_code;
  logic       scan_valid;
  logic [5:0] freq_code;
  logic       gate;
  logic       note_strobe;
  logic [2:0] stack_depth;

  modport master (
    output scan_code, scan_valid,
    input  freq_code, gate, note_strobe, stack_depth
  );

  modport slave (
    input  scan_code, scan_valid,
    output freq_code, gate, note_strobe, stack_depth
  );

endinterface

// File: rtl/key_note_tracker_key_to_code.sv
// Combinational PS/2 set-2 make code to note code (0..47) lookup; four keyboard rows of 12.
module key_to_code #(
  parameter logic [5:0] SILENT_CODE = key_note_tracker_pkg::SILENT_CODE
) (
  input  logic [7:0] scan_code,
  output logic [5:0] note_code
);

  always_comb begin
    note_code = SILENT_CODE;
    case (scan_code)
      8'h0E: note_code = 6'd0;   8'h16: note_code = 6'd1;   8'h1E: note_code = 6'd2;
      8'h26: note_code = 6'd3;   8'h25: note_code = 6'd4;   8'h2E: note_code = 6'd5;
      8'h36: note_code = 6'd6;   8'h3D: note_code = 6'd7;   8'h3E: note_code = 6'd8;
      8'h46: note_code = 6'd9;   8'h45: note_code = 6'd10;  8'h4E: note_code = 6'd11;
      8'h0D: note_code = 6'd12;  8'h15: note_code = 6'd13;  8'h1D: note_code = 6'd14;
      8'h24: note_code = 6'd15;  8'h2D: note_code = 6'd16;  8'h2C: note_code = 6'd17;
      8'h35: note_code = 6'd18;  8'h3C: note_code = 6'd19;  8'h43: note_code = 6'd20;
      8'h44: note_code = 6'd21;  8'h4D: note_code = 6'd22;  8'h54: note_code = 6'd23;
      8'h58: note_code = 6'd24;  8'h1C: note_code = 6'd25;  8'h1B: note_code = 6'd26;
      8'h23: note_code = 6'd27;  8'h2B: note_code = 6'd28;  8'h34: note_code = 6'd29;
      8'h33: note_code = 6'd30;  8'h3B: note_code = 6'd31;  8'h42: note_code = 6'd32;
      8'h4B: note_code = 6'd33;  8'h4C: note_code = 6'd34;  8'h52: note_code = 6'd35;
      8'h12: note_code = 6'd36;  8'h1A: note_code = 6'd37;  8'h22: note_code = 6'd38;
      8'h21: note_code = 6'd39;  8'h2A: note_code = 6'd40;  8'h32: note_code = 6'd41;
      8'h31: note_code = 6'd42;  8'h3A: note_code = 6'd43;  8'h41: note_code = 6'd44;
      8'h49: note_code = 6'd45;  8'h4A: note_code = 6'd46;  8'h59: note_code = 6'd47;
      default: note_code = SILENT_CODE;
    endcase
  end

endmodule

// File: rtl/key_note_tracker.sv
// PS/2 keyboard note tracker: held-note stack (multi-slot with KEY_NOTE_STACK_EN, else one slot),
// outputs registered on the edge that samples scan_valid; no backpressure, every strobed byte is consumed.
module key_note_tracker #(
  parameter int         STACK_DEPTH = 4,
  parameter logic [5:0] SILENT_CODE = key_note_tracker_pkg::SILENT_CODE
) (
  input logic               CLOCK_50,
  input logic               AUD_DACLRCK,
  key_note_tracker_if.slave bus
);
  import key_note_tracker_pkg::*;

`ifdef KEY_NOTE_STACK_EN
  localparam int DEPTH = STACK_DEPTH;
`else
  // STACK_DEPTH has no effect in the single-slot build.
  localparam int DEPTH = 1 + 0 * STACK_DEPTH;
`endif

  logic [1:0]  rst_sync;
  logic        rst_n;
  kbd_state_t  state;
  logic        make_evt, brk_evt, is_note, held, found;
  logic [5:0]  note;
  logic [5:0]  stk_q [DEPTH];
  logic [5:0]  stk_n [DEPTH];
  logic [2:0]  cnt_q, cnt_n;
  logic [5:0]  freq_q, freq_n;
  logic        gate_q, gate_n, strobe_q;

  // Assert asynchronously, release two edges later on CLOCK_50.
  always_ff @(posedge CLOCK_50 or negedge AUD_DACLRCK) begin
    if (!AUD_DACLRCK) rst_sync <= 2'b00;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (bus.scan_valid) begin
      case (state)
        IDLE:    state <= (bus.scan_code == BRK_PREFIX) ? BRK :
                          (bus.scan_code == EXT_PREFIX) ? EXT : IDLE;
        EXT:     state <= (bus.scan_code == BRK_PREFIX) ? EXT_BRK : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign make_evt = bus.scan_valid && (state == IDLE) &&
                    (bus.scan_code != BRK_PREFIX) && (bus.scan_code != EXT_PREFIX);
  assign brk_evt  = bus.scan_valid && (state == BRK);

  key_to_code #(.SILENT_CODE(SILENT_CODE)) u_key_to_code (
    .scan_code (bus.scan_code),
    .note_code (note)
  );
  assign is_note = (note != SILENT_CODE);

  // Slot 0 is the oldest note, slot cnt-1 the most recent; notes are unique in the stack.
  always_comb begin
    stk_n = stk_q;
    cnt_n = cnt_q;
    held  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ((3'(i) < cnt_q) && (stk_q[i] == note)) held = 1'b1;
    if (make_evt && is_note && !held) begin
      if (cnt_q < 3'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++)
          if (3'(i) == cnt_q) stk_n[i] = note;
        cnt_n = cnt_q + 3'd1;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) stk_n[i] = stk_q[i + 1];
        stk_n[DEPTH - 1] = note;
      end
    end else if (brk_evt && is_note && held) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if ((3'(i) < cnt_q) && (stk_q[i] == note)) found = 1'b1;
        if (found) stk_n[i] = stk_q[i + 1];
      end
      cnt_n = cnt_q - 3'd1;
    end
    freq_n = SILENT_CODE;
    for (int i = 0; i < DEPTH; i++)
      if (3'(i + 1) == cnt_n) freq_n = stk_n[i];
    gate_n = (cnt_n != 3'd0);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      cnt_q    <= 3'd0;
      freq_q   <= SILENT_CODE;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      stk_q    <= stk_n;
      cnt_q    <= cnt_n;
      freq_q   <= freq_n;
      gate_q   <= gate_n;
      strobe_q <= (freq_n != freq_q) || (gate_n != gate_q);
    end
  end

  assign bus.freq_code   = freq_q;
  assign bus.gate        = gate_q;
  assign bus.note_strobe = strobe_q;
  assign bus.stack_depth = cnt_q;

endmodule

// File: tb/tb_key_note_tracker.sv
// Directed bench for key_note_tracker; expectations adapt to KEY_NOTE_STACK_EN.
module tb_key_note_tracker;

  logic CLOCK_50;
  logic AUD_DACLRCK;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_strobe = 0;
  int   s0;

  key_note_tracker_if bus();

  key_note_tracker dut (
    .CLOCK_50    (CLOCK_50),
    .AUD_DACLRCK (AUD_DACLRCK),
    .bus         (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Strobe is high for one full cycle after an edge; sample it once, mid-cycle.
  always @(posedge CLOCK_50) begin
    #2;
    if (bus.note_strobe === 1'b1) n_strobe++;
  end

  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    bus.scan_code  = b;
    bus.scan_valid = 1'b1;
    @(negedge CLOCK_50);
    bus.scan_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [5:0] f, input logic g, input logic [2:0] d);
    n_cmp++;
    if (bus.freq_code !== f || bus.gate !== g || bus.stack_depth !== d) begin
      n_err++;
      $display("FAIL %s: got freq=%0d gate=%b depth=%0d, want freq=%0d gate=%b depth=%0d",
               name, bus.freq_code, bus.gate, bus.stack_depth, f, g, d);
    end
  endtask

  task automatic test_reset();
    AUD_DACLRCK    = 1'b0;
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    expect_out("reset_outputs", 6'd48, 1'b0, 3'd0);
    n_cmp++;
    if (bus.note_strobe !== 1'b0) begin
      n_err++; $display("FAIL reset_strobe: got %b want 0", bus.note_strobe);
    end
    AUD_DACLRCK = 1'b1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic test_make_break();
    @(negedge CLOCK_50);
    bus.scan_code  = 8'h1C;
    bus.scan_valid = 1'b1;
    #1;
    expect_out("make_before_edge", 6'd48, 1'b0, 3'd0);
    @(posedge CLOCK_50); #1;
    expect_out("make_after_edge", 6'd25, 1'b1, 3'd1);
    n_cmp++;
    if (bus.note_strobe !== 1'b1) begin
      n_err++; $display("FAIL make_strobe_high: got %b want 1", bus.note_strobe);
    end
    @(negedge CLOCK_50);
    bus.scan_valid = 1'b0;
    @(posedge CLOCK_50); #1;
    n_cmp++;
    if (bus.note_strobe !== 1'b0) begin
      n_err++; $display("FAIL make_strobe_single: got %b want 0", bus.note_strobe);
    end
    send(8'hF0);
    expect_out("break_prefix_only", 6'd25, 1'b1, 3'd1);
    s0 = n_strobe;
    send(8'h1C);
    expect_out("break_to_silent", 6'd48, 1'b0, 3'd0);
    n_cmp++;
    if (n_strobe - s0 !== 1) begin
      n_err++; $display("FAIL break_strobe_count: got %0d want 1", n_strobe - s0);
    end
  endtask

  task automatic test_typematic();
    s0 = n_strobe;
    for (int i = 0; i < 3; i++) send(8'h1C);
    expect_out("typematic_state", 6'd25, 1'b1, 3'd1);
    n_cmp++;
    if (n_strobe - s0 !== 1) begin
      n_err++; $display("FAIL typematic_strobes: got %0d want 1", n_strobe - s0);
    end
    send(8'hF0); send(8'h1C);
    expect_out("typematic_release", 6'd48, 1'b0, 3'd0);
  endtask

  task automatic test_priority();
    send(8'h1C); send(8'h1B);
    expect_out("second_note_on_top", 6'd26, 1'b1, `ifdef KEY_NOTE_STACK_EN 3'd2 `else 3'd1 `endif);
    send(8'hF0); send(8'h1B);
`ifdef KEY_NOTE_STACK_EN
    expect_out("fallback_to_first", 6'd25, 1'b1, 3'd1);
    send(8'hF0); send(8'h1C);
`else
    expect_out("single_slot_silence", 6'd48, 1'b0, 3'd0);
    send(8'hF0); send(8'h1C);
`endif
    expect_out("priority_cleanup", 6'd48, 1'b0, 3'd0);
  endtask

  task automatic test_stack();
`ifdef KEY_NOTE_STACK_EN
    send(8'h0D); send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    expect_out("stack_full_drop_oldest", 6'd16, 1'b1, 3'd4);
    send(8'hF0); send(8'h2D);
    expect_out("stack_pop_top", 6'd15, 1'b1, 3'd3);
    s0 = n_strobe;
    send(8'hF0); send(8'h1D);
    expect_out("stack_remove_middle", 6'd15, 1'b1, 3'd2);
    send(8'hF0); send(8'h0D);
    expect_out("stack_break_dropped", 6'd15, 1'b1, 3'd2);
    n_cmp++;
    if (n_strobe - s0 !== 0) begin
      n_err++; $display("FAIL stack_no_strobe: got %0d want 0", n_strobe - s0);
    end
    send(8'hF0); send(8'h24);
    expect_out("stack_compacted", 6'd13, 1'b1, 3'd1);
    send(8'hF0); send(8'h15);
`else
    send(8'h0D); send(8'h15);
    expect_out("single_replace", 6'd13, 1'b1, 3'd1);
    s0 = n_strobe;
    send(8'hF0); send(8'h0D);
    expect_out("single_break_other", 6'd13, 1'b1, 3'd1);
    n_cmp++;
    if (n_strobe - s0 !== 0) begin
      n_err++; $display("FAIL single_no_strobe: got %0d want 0", n_strobe - s0);
    end
    send(8'hF0); send(8'h15);
`endif
    expect_out("stack_cleanup", 6'd48, 1'b0, 3'd0);
  endtask

  task automatic test_ignored();
    send(8'h1C);
    s0 = n_strobe;
    send(8'hE0); send(8'hF0); send(8'h1C);
    expect_out("ext_break_ignored", 6'd25, 1'b1, 3'd1);
    send(8'hE0); send(8'h1B);
    expect_out("ext_make_ignored", 6'd25, 1'b1, 3'd1);
    send(8'h29);
    send(8'hF0); send(8'h29);
    expect_out("non_note_ignored", 6'd25, 1'b1, 3'd1);
    n_cmp++;
    if (n_strobe - s0 !== 0) begin
      n_err++; $display("FAIL ignored_strobes: got %0d want 0", n_strobe - s0);
    end
    send(8'hF0); send(8'h1C);
    expect_out("ignored_cleanup", 6'd48, 1'b0, 3'd0);
  endtask

  task automatic test_reset_mid_break();
    send(8'h1C);
    send(8'hF0);
    #3;
    AUD_DACLRCK = 1'b0;
    #1;
    expect_out("async_reset_immediate", 6'd48, 1'b0, 3'd0);
    repeat (2) @(negedge CLOCK_50);
    AUD_DACLRCK = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    send(8'h1C);
    expect_out("post_reset_make", 6'd25, 1'b1, 3'd1);
    send(8'hF0); send(8'h1C);
    expect_out("post_reset_release", 6'd48, 1'b0, 3'd0);
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_typematic();
    test_priority();
    test_stack();
    test_ignored();
    test_reset_mid_break();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
